// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer controller.
//   - Channel field encodings, used as wr_addr[1:0] on channel writes and as
//     the low two bits of the load step counter.
//   - Global register addresses.
//   - Controller state encoding.
package pulse_seq_pkg;

  localparam logic [1:0] FLD_INIT_STATE = 2'd0;
  localparam logic [1:0] FLD_INIT_COUNT = 2'd1;
  localparam logic [1:0] FLD_HI         = 2'd2;
  localparam logic [1:0] FLD_LO         = 2'd3;

  localparam int GREG_DURATION = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_seq_shadow_regs.sv
// Shadow register file for the pulse sequencer bank.
// Holds N_CH x 4 channel fields and the global run duration register.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr_en/addr/data     host write port
//   wr_allow            write enable from the controller (high only in IDLE)
//   rd_ch, rd_fld       combinational read address
//   rd_data             read data; a write accepted this cycle to the same
//                       address is forwarded, so a load starting in the same
//                       cycle sees the new value
//   duration            current duration register
//   wr_err              registered one-cycle pulse for a rejected write
module pulse_seq_shadow_regs
  import pulse_seq_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CW   = 32,
  localparam int ADDR_W = $clog2(N_CH) + 3,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_allow,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CW-1:0]     wr_data,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [1:0]        rd_fld,
  output logic [CW-1:0]     rd_data,
  output logic [CW-1:0]     duration,
  output logic              wr_err
);

  localparam int LW = ADDR_W - 1;

  logic            is_global_s;
  logic [LW-1:0]   low_s;
  logic [LW-1:0]   ch_num_s;
  logic [CH_W-1:0] ch_idx_s;
  logic [1:0]      fld_s;
  logic            addr_ok_s;
  logic            accept_s;
  logic            ch_wr_s;

  logic [CW-1:0]   shadow_r [N_CH][4];
  logic [CW-1:0]   duration_r;
  logic            wr_err_r;

  // Address decode and range check of the host write.
  always_comb begin
    is_global_s = wr_addr[ADDR_W-1];
    low_s       = wr_addr[LW-1:0];
    fld_s       = low_s[1:0];
    ch_num_s    = low_s >> 2;
    ch_idx_s    = ch_num_s[CH_W-1:0];
    if (is_global_s) begin
      addr_ok_s = (low_s == LW'(GREG_DURATION));
    end else begin
      addr_ok_s = (ch_num_s < LW'(N_CH));
    end
    accept_s = wr_en & wr_allow & addr_ok_s;
    ch_wr_s  = accept_s & ~is_global_s;
  end

  // Channel shadow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int f = 0; f < 4; f++) begin
          shadow_r[c][f] <= {CW{1'b0}};
        end
      end
    end else if (ch_wr_s) begin
      shadow_r[ch_idx_s][fld_s] <= wr_data;
    end
  end

  // Global duration register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duration_r <= {CW{1'b0}};
    end else if (accept_s && is_global_s) begin
      duration_r <= wr_data;
    end
  end

  // Rejected-write flag: busy or out-of-range address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= wr_en & ~accept_s;
    end
  end

  // Read port with same-cycle write forwarding.
  always_comb begin
    if (ch_wr_s && (ch_idx_s == rd_ch) && (fld_s == rd_fld)) begin
      rd_data = wr_data;
    end else begin
      rd_data = shadow_r[rd_ch][rd_fld];
    end
  end

  assign duration = duration_r;
  assign wr_err   = wr_err_r;

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse sequencer bank controller.
// Loads every channel's four fields serially over a shared value bus with
// per-channel set strobes, then holds a common operate for a programmed
// number of cycles (duration 0 = until stopped).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data    host register writes (accepted in IDLE only)
//   start, stop                single-cycle run control; stop wins over start
//   seq_value                  shared value bus
//   seq_set_*                  per-channel field strobes, one at a time
//   seq_operate                common operate
//   busy                       high in LOAD or RUN
//   done                       one-cycle pulse at the natural end of a timed run
//   wr_err                     one-cycle pulse for a rejected write
// All outputs are registered.
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CW   = 32,
  localparam int ADDR_W = $clog2(N_CH) + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CW-1:0]     wr_data,
  input  logic              start,
  input  logic              stop,
  output logic [CW-1:0]     seq_value,
  output logic [N_CH-1:0]   seq_set_initial_state,
  output logic [N_CH-1:0]   seq_set_initial_count,
  output logic [N_CH-1:0]   seq_set_hi_count,
  output logic [N_CH-1:0]   seq_set_lo_count,
  output logic              seq_operate,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int N_STEP = 4 * N_CH;
  localparam int STEP_W = $clog2(N_STEP + 1);

  state_e            state_r, state_nxt_s;
  logic [STEP_W-1:0] step_r, step_nxt_s;
  logic [CW-1:0]     count_r, count_nxt_s;
  logic [CW-1:0]     seq_value_r, value_nxt_s;
  logic [N_CH-1:0]   set_state_r, set_state_nxt_s;
  logic [N_CH-1:0]   set_count_r, set_count_nxt_s;
  logic [N_CH-1:0]   set_hi_r, set_hi_nxt_s;
  logic [N_CH-1:0]   set_lo_r, set_lo_nxt_s;
  logic              operate_r, operate_nxt_s;
  logic              busy_r;
  logic              done_r, done_nxt_s;

  logic              issue_s;
  logic [CH_W-1:0]   issue_ch_s;
  logic [1:0]        issue_fld_s;
  logic [N_CH-1:0]   ch_mask_s;
  logic [CW-1:0]     rd_data_s;
  logic [CW-1:0]     duration_s;

  // step_r is held at 0 in IDLE, so it always names the step issued next.
  assign issue_ch_s  = CH_W'(step_r >> 2);
  assign issue_fld_s = step_r[1:0];
  assign ch_mask_s   = N_CH'(1'b1) << issue_ch_s;

  pulse_seq_shadow_regs #(
    .N_CH (N_CH),
    .CW   (CW)
  ) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_allow (state_r == IDLE),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_ch    (issue_ch_s),
    .rd_fld   (issue_fld_s),
    .rd_data  (rd_data_s),
    .duration (duration_s),
    .wr_err   (wr_err)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s     = state_r;
    step_nxt_s      = step_r;
    count_nxt_s     = count_r;
    value_nxt_s     = seq_value_r;
    set_state_nxt_s = {N_CH{1'b0}};
    set_count_nxt_s = {N_CH{1'b0}};
    set_hi_nxt_s    = {N_CH{1'b0}};
    set_lo_nxt_s    = {N_CH{1'b0}};
    operate_nxt_s   = 1'b0;
    done_nxt_s      = 1'b0;
    issue_s         = 1'b0;

    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          issue_s     = 1'b1;
          step_nxt_s  = STEP_W'(1);
          state_nxt_s = LOAD;
        end else begin
          step_nxt_s  = {STEP_W{1'b0}};
        end
      end
      LOAD: begin
        if (stop) begin
          state_nxt_s = IDLE;
          step_nxt_s  = {STEP_W{1'b0}};
        end else if (step_r == STEP_W'(N_STEP)) begin
          state_nxt_s   = RUN;
          step_nxt_s    = {STEP_W{1'b0}};
          operate_nxt_s = 1'b1;
          count_nxt_s   = duration_s;
        end else begin
          issue_s    = 1'b1;
          step_nxt_s = step_r + STEP_W'(1);
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt_s = IDLE;
        end else if (count_r == CW'(1)) begin
          // count==1 marks the last operate cycle of a timed run.
          state_nxt_s = IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          operate_nxt_s = 1'b1;
          // A zero count means an untimed run; hold it rather than wrap.
          if (count_r != {CW{1'b0}}) begin
            count_nxt_s = count_r - CW'(1);
          end else begin
            count_nxt_s = count_r;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
        step_nxt_s  = {STEP_W{1'b0}};
      end
    endcase

    if (issue_s) begin
      value_nxt_s = rd_data_s;
      case (issue_fld_s)
        FLD_INIT_STATE: set_state_nxt_s = ch_mask_s;
        FLD_INIT_COUNT: set_count_nxt_s = ch_mask_s;
        FLD_HI:         set_hi_nxt_s    = ch_mask_s;
        FLD_LO:         set_lo_nxt_s    = ch_mask_s;
        default:        set_state_nxt_s = {N_CH{1'b0}};
      endcase
    end else begin
      value_nxt_s = seq_value_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      step_r      <= {STEP_W{1'b0}};
      count_r     <= {CW{1'b0}};
      seq_value_r <= {CW{1'b0}};
      set_state_r <= {N_CH{1'b0}};
      set_count_r <= {N_CH{1'b0}};
      set_hi_r    <= {N_CH{1'b0}};
      set_lo_r    <= {N_CH{1'b0}};
      operate_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      step_r      <= step_nxt_s;
      count_r     <= count_nxt_s;
      seq_value_r <= value_nxt_s;
      set_state_r <= set_state_nxt_s;
      set_count_r <= set_count_nxt_s;
      set_hi_r    <= set_hi_nxt_s;
      set_lo_r    <= set_lo_nxt_s;
      operate_r   <= operate_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= done_nxt_s;
    end
  end

  assign seq_value             = seq_value_r;
  assign seq_set_initial_state = set_state_r;
  assign seq_set_initial_count = set_count_r;
  assign seq_set_hi_count      = set_hi_r;
  assign seq_set_lo_count      = set_lo_r;
  assign seq_operate           = operate_r;
  assign busy                  = busy_r;
  assign done                  = done_r;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench for pulse_seq_ctrl (N_CH=4, CW=32).
module tb_pulse_seq_ctrl;

  localparam int N_CH   = 4;
  localparam int CW     = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CW-1:0]     wr_data;
  logic              start;
  logic              stop;
  logic [CW-1:0]     seq_value;
  logic [N_CH-1:0]   seq_set_initial_state;
  logic [N_CH-1:0]   seq_set_initial_count;
  logic [N_CH-1:0]   seq_set_hi_count;
  logic [N_CH-1:0]   seq_set_lo_count;
  logic              seq_operate;
  logic              busy;
  logic              done;
  logic              wr_err;

  int total = 0;
  int bad   = 0;

  logic [CW-1:0] mdl [4][4];
  logic [CW-1:0] mdl_d;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     data;
    logic              err;
  } wr_vec_t;

  wr_vec_t vecs [10];

  pulse_seq_ctrl #(.N_CH(N_CH), .CW(CW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .wr_en                 (wr_en),
    .wr_addr               (wr_addr),
    .wr_data               (wr_data),
    .start                 (start),
    .stop                  (stop),
    .seq_value             (seq_value),
    .seq_set_initial_state (seq_set_initial_state),
    .seq_set_initial_count (seq_set_initial_count),
    .seq_set_hi_count      (seq_set_hi_count),
    .seq_set_lo_count      (seq_set_lo_count),
    .seq_operate           (seq_operate),
    .busy                  (busy),
    .done                  (done),
    .wr_err                (wr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] strobes();
    return {seq_set_lo_count, seq_set_hi_count, seq_set_initial_count, seq_set_initial_state};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [CW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Pulses start in the current cycle, checks all 16 load steps against the
  // model and returns in the first operate cycle.
  task automatic start_and_check_load(input string tag);
    int c;
    int f;
    logic [15:0] es;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int s = 0; s < 16; s++) begin
      c  = s / 4;
      f  = s % 4;
      es = 16'd1 << (f * 4 + c);
      chk($sformatf("%s strobe s%0d", tag, s), strobes(), es);
      chk($sformatf("%s value s%0d", tag, s), seq_value, mdl[c][f]);
      chk($sformatf("%s busy/op s%0d", tag, s), {busy, seq_operate}, 2'b10);
      tick();
    end
    chk({tag, " operate rise"}, seq_operate, 1'b1);
    chk({tag, " run strobes"}, strobes(), 16'h0);
    chk({tag, " run busy"}, busy, 1'b1);
  endtask

  // Counts operate cycles; returns in the first cycle with operate low.
  task automatic run_check(input string tag, input int exp_d);
    int n;
    n = 0;
    while (seq_operate === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    chk({tag, " run length"}, n, exp_d);
    chk({tag, " done pulse"}, done, 1'b1);
    chk({tag, " busy after run"}, busy, 1'b0);
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk({tag, " stop outputs"}, {strobes(), seq_operate, busy, done}, 19'h0);
  endtask

  initial begin
    logic quiet;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    stop    = 1'b0;
    mdl_d   = 32'd0;
    for (int c = 0; c < 4; c++)
      for (int f = 0; f < 4; f++)
        mdl[c][f] = 32'd0;

    vecs[0] = '{5'b01010, 32'h0000_0010, 1'b0};  // ch2 hi
    vecs[1] = '{5'b01011, 32'h0000_0020, 1'b0};  // ch2 lo
    vecs[2] = '{5'b01001, 32'h0000_0005, 1'b0};  // ch2 init_count
    vecs[3] = '{5'b01000, 32'h0000_0000, 1'b0};  // ch2 init_state
    vecs[4] = '{5'b00010, 32'hAAAA_0001, 1'b0};  // ch0 hi
    vecs[5] = '{5'b01100, 32'h0000_0001, 1'b0};  // ch3 init_state
    vecs[6] = '{5'b00111, 32'h0000_1234, 1'b0};  // ch1 lo
    vecs[7] = '{5'b10000, 32'd100,       1'b0};  // duration
    vecs[8] = '{5'b10001, 32'hDEAD_0001, 1'b1};  // global field 1
    vecs[9] = '{5'b11111, 32'hDEAD_0002, 1'b1};  // global field 15

    #12;
    chk("reset outputs", {seq_value, strobes(), seq_operate, busy, done, wr_err}, 52'h0);
    #1 reset = 1'b0;
    tick();

    // Register writes from the table.
    for (int i = 0; i < 10; i++) begin
      do_write(vecs[i].addr, vecs[i].data);
      chk($sformatf("wr_err vec%0d", i), wr_err, vecs[i].err);
      tick();
      chk($sformatf("wr_err clear vec%0d", i), wr_err, 1'b0);
      if (!vecs[i].err) begin
        if (vecs[i].addr[4]) mdl_d = vecs[i].data;
        else mdl[vecs[i].addr[3:2]][vecs[i].addr[1:0]] = vecs[i].data;
      end
    end

    // Timed run, D=100.
    start_and_check_load("d100");
    run_check("d100", 100);
    tick();
    chk("d100 done clear", done, 1'b0);

    // Untimed run, rejected write in RUN, stop 50 cycles after operate rises.
    do_write(5'b10000, 32'd0);
    mdl_d = 32'd0;
    start_and_check_load("d0");
    do_write(5'b00010, 32'h0000_00FF);
    chk("wr in run err", wr_err, 1'b1);
    repeat (49) tick();
    chk("d0 still operating", seq_operate, 1'b1);
    do_stop("d0");
    quiet = 1'b1;
    repeat (5) begin
      tick();
      if (done !== 1'b0) quiet = 1'b0;
    end
    chk("d0 no done", quiet, 1'b1);
    start_and_check_load("reload");
    do_stop("reload");

    // Stop at load step 6.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("step6 strobe", strobes(), 16'h0200);
    chk("step6 value", seq_value, mdl[1][2]);
    do_stop("load abort");
    quiet = 1'b1;
    repeat (20) begin
      tick();
      if ({strobes(), seq_operate, busy, done} !== 19'h0) quiet = 1'b0;
    end
    chk("abort quiet", quiet, 1'b1);
    start_and_check_load("after abort");
    do_stop("after abort");

    // Start and stop together in IDLE.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      if ({strobes(), seq_operate, busy} !== 18'h0) quiet = 1'b0;
      tick();
    end
    chk("start+stop idle", quiet, 1'b1);

    // D=3 run with a new start on the done cycle.
    do_write(5'b10000, 32'd3);
    mdl_d = 32'd3;
    start_and_check_load("d3a");
    run_check("d3a", 3);
    start_and_check_load("d3b");
    run_check("d3b", 3);
    tick();
    chk("d3b done clear", done, 1'b0);

    // Asynchronous reset in the middle of a run.
    do_write(5'b10000, 32'd0);
    mdl_d = 32'd0;
    start_and_check_load("pre reset");
    repeat (3) tick();
    #3 reset = 1'b1;
    #1;
    chk("async reset outputs", {seq_value, strobes(), seq_operate, busy, done, wr_err}, 52'h0);
    for (int c = 0; c < 4; c++)
      for (int f = 0; f < 4; f++)
        mdl[c][f] = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Write committed in the start cycle is used by step 0.
    wr_en   = 1'b1;
    wr_addr = 5'b00000;
    wr_data = 32'h0000_005A;
    mdl[0][0] = 32'h0000_005A;
    start_and_check_load("post reset");
    repeat (10) tick();
    chk("post reset untimed", seq_operate, 1'b1);
    do_stop("post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
